// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
//
// 8N1 UART receiver, LSB first. The asynchronous serial line is brought into
// the i_clk domain through a two-flop synchroniser. The start bit is
// re-checked half a bit after its falling edge. Each data bit and the stop
// bit are then sampled one full bit period apart, which lands them at
// mid-bit. A completed byte is presented on a valid/ready handshake. Framing
// errors and overruns are reported as single-cycle pulses. The receiver
// never back-pressures the line.
//
// Ports:
//   i_clk        system clock, all logic on its rising edge
//   i_rst        asynchronous, active-low reset
//   i_rx         serial line (asynchronous, idle high)
//   i_ready      consumer can take o_data this cycle
//   o_data       received byte, stable while o_valid is high
//   o_valid      o_data holds an unconsumed byte
//   o_frame_err  one-cycle pulse: stop bit sampled low, byte discarded
//   o_overrun    one-cycle pulse: good byte dropped, output still occupied
// ----------------------------------------------------------------------------
module uart_rx #(
    parameter int input_clk_hz = 1_000_000,
    parameter int baud_rate    = 9600
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    input  logic       i_ready,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_overrun
);

    localparam int CLKS_PER_BIT = (input_clk_hz + baud_rate / 2) / baud_rate;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // With fewer than four clocks per bit there is no meaningful mid-bit
    // sample point once the synchroniser delay is accounted for.
    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_cfg
            $error("uart_rx: CLKS_PER_BIT must be at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           r_state,     w_state;
    logic [CNT_W-1:0] r_clk_cnt,   w_clk_cnt;
    logic [2:0]       r_bit_idx,   w_bit_idx;
    logic [7:0]       r_shift,     w_shift;
    logic [7:0]       r_data,      w_data;
    logic             r_valid,     w_valid;
    logic             r_frame_err, w_frame_err;
    logic             r_overrun,   w_overrun;

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic w_rx_s;

    assign w_rx_s = r_sync2;

    // Synchroniser and edge-detect history reset high, so an idle line
    // coming out of reset never looks like a falling edge.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= S_IDLE;
            r_clk_cnt   <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_clk_cnt   <= w_clk_cnt;
            r_bit_idx   <= w_bit_idx;
            r_shift     <= w_shift;
            r_data      <= w_data;
            r_valid     <= w_valid;
            r_frame_err <= w_frame_err;
            r_overrun   <= w_overrun;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_clk_cnt   = r_clk_cnt;
        w_bit_idx   = r_bit_idx;
        w_shift     = r_shift;
        w_data      = r_data;
        // A transfer this cycle empties the output; a newly completed byte
        // below may refill it on the same edge.
        w_valid     = r_valid & ~i_ready;
        w_frame_err = 1'b0;
        w_overrun   = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                // Only a genuine high-to-low transition starts a frame, so a
                // line held low (break) does not retrigger.
                if (r_prev && !w_rx_s) begin
                    w_state   = S_START;
                    w_clk_cnt = '0;
                end
            end

            S_START: begin
                if (r_clk_cnt == MID_CNT) begin
                    w_clk_cnt = '0;
                    if (!w_rx_s) begin
                        w_state   = S_DATA;
                        w_bit_idx = '0;
                    end else begin
                        w_state = S_IDLE;
                    end
                end else begin
                    w_clk_cnt = r_clk_cnt + CNT_ONE;
                end
            end

            S_DATA: begin
                if (r_clk_cnt == LAST_CNT) begin
                    // Shift right with the new bit at the MSB: after eight
                    // samples the first (LSB) bit has arrived at bit 0.
                    w_shift   = {w_rx_s, r_shift[7:1]};
                    w_clk_cnt = '0;
                    w_bit_idx = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state = S_STOP;
                    end
                end else begin
                    w_clk_cnt = r_clk_cnt + CNT_ONE;
                end
            end

            S_STOP: begin
                if (r_clk_cnt == LAST_CNT) begin
                    w_clk_cnt = '0;
                    w_state   = S_IDLE;
                    if (!w_rx_s) begin
                        w_frame_err = 1'b1;
                    end else if (!r_valid || i_ready) begin
                        w_data  = r_shift;
                        w_valid = 1'b1;
                    end else begin
                        w_overrun = 1'b1;
                    end
                end else begin
                    w_clk_cnt = r_clk_cnt + CNT_ONE;
                end
            end

            default: begin
                w_state   = S_IDLE;
                w_clk_cnt = '0;
            end
        endcase
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;

endmodule
